// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types for the fetch front end: depth, reset PC, queue entry.
// Entry layout: {instr, pc4}; FSM states BOOT/RUN.
package fetch_prefetch_queue_pkg;

  localparam int          FETCH_DEPTH    = 4;
  localparam int          FETCH_ADDR_W   = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch bundle: imem req/gnt/rvalid side plus IF/ID valid/ready side.
// master = fetch unit, slave = memory + decode environment.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc4;
  logic              out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc4,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc4,
    output out_ready
  );

endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// In-order entry queue: flush, simultaneous push/pop, occupancy count.
// Ports: clk, rst_n, flush, push/din, pop/dout, count.
module fetch_prefetch_queue_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: credit-gated sequential fetch, in-order queue, redirect flush.
// Ports: clk, rst_n, redirect, redirect_pc, bus (imem + IF/ID handshake, master).
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH  = FETCH_DEPTH,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 redirect,
  input logic [ADDR_W-1:0]    redirect_pc,
  fetch_prefetch_queue_if.master bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] rpc_al;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW:0]       credit;
  logic              issue;
  logic              fire;
  logic              push;
  logic              pop;
  logic              rsp_drop;
  fetch_entry_t      din;
  fetch_entry_t      head;

  assign credit = {1'b0, count} + {1'b0, outstanding};
  assign issue  = (state == RUN) && !redirect
                  && (credit < (CW+1)'(DEPTH));
  assign fire   = issue && bus.imem_gnt;

  // Every response is either dropped (stale) or kept.
  assign rsp_drop = bus.imem_rvalid && (drop_cnt != '0);
  assign push     = bus.imem_rvalid && (drop_cnt == '0)
                    && !redirect;
  assign pop      = bus.out_valid && bus.out_ready
                    && !redirect;

  assign rpc_al    = redirect_pc & ~ADDR_W'(3);
  assign din.instr = bus.imem_rdata;
  assign din.pc4   = resp_pc + ADDR_W'(4);

  fetch_prefetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? head.instr : '0;
  assign bus.out_pc4   = bus.out_valid ? head.pc4 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= RUN;
      unique case (1'b1)
        fire && !bus.imem_rvalid:
          outstanding <= outstanding + 1'b1;
        !fire && bus.imem_rvalid:
          outstanding <= outstanding - 1'b1;
        default:
          outstanding <= outstanding;
      endcase
      if (redirect) begin
        fetch_pc <= rpc_al;
        resp_pc  <= rpc_al;
        // No issue this cycle, so this is every response still due.
        drop_cnt <= outstanding - CW'(bus.imem_rvalid);
      end else begin
        if (fire)     fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push)     resp_pc  <= resp_pc + ADDR_W'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed + random bench for fetch_prefetch_queue with an in-order memory model.
// Model tracks request epochs: responses issued before a redirect must never surface.
module tb_fetch_prefetch_queue;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.ADDR_W(32)) bus ();

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  req_t        q[$];
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          tb_count = 0;
  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;
  int          issues = 0;
  int          i0;
  logic [31:0] exp_issue = '0;
  logic [31:0] exp_pc4 = 32'h4;
  bit          booted = 0;
  bit          stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a,
                                       input int ep);
    logic [31:0] e;
    e = ep;
    return {e[7:0], a[23:0]};
  endfunction

  task automatic drive_mem();
    if (rst_n && !stall && q.size() > 0 && q[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word(q[0].addr, q[0].ep);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hdeadbeef;
    end
  endtask

  task automatic step();
    logic        s_req, s_gnt, s_rv, s_red, s_pop;
    logic [31:0] s_addr, s_rpc;
    req_t        r;
    drive_mem();
    #1;
    s_req  = bus.imem_req;
    s_gnt  = bus.imem_gnt;
    s_addr = bus.imem_addr;
    s_rv   = bus.imem_rvalid;
    s_red  = redirect;
    s_rpc  = redirect_pc;
    s_pop  = (tb_count > 0) && bus.out_ready && !redirect;
    chk("req", 32'(s_req),
        32'(booted && !redirect && (tb_count + q.size()) < 4));
    chk("valid", 32'(bus.out_valid), 32'(tb_count > 0));
    if (s_req && s_gnt) chk("issue_addr", s_addr, exp_issue);
    if (s_pop) begin
      chk("pc4", bus.out_pc4, exp_pc4);
      chk("instr", bus.out_instr, word(exp_pc4 - 32'h4, epoch));
    end
    @(posedge clk);
    #1;
    cyc++;
    booted = 1;
    if (s_req && s_gnt) begin
      r.addr = s_addr;
      r.ep   = epoch;
      r.due  = cyc + lat - 1;
      q.push_back(r);
      exp_issue += 32'h4;
      issues++;
    end
    if (s_rv) begin
      r = q.pop_front();
      if (r.ep == epoch && !s_red) tb_count++;
    end
    if (s_pop) begin
      tb_count--;
      exp_pc4 += 32'h4;
      delivered++;
    end
    if (s_red) begin
      tb_count  = 0;
      epoch++;
      exp_issue = s_rpc & ~32'h3;
      exp_pc4   = exp_issue + 32'h4;
    end
    chk("credit", 32'(q.size() <= 4), 32'h1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_pc4", bus.out_pc4, 32'h0);
    q.delete();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    redirect  = 1'b0;
    tb_count  = 0;
    epoch++;
    exp_issue = 32'h0;
    exp_pc4   = 32'h4;
    booted    = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !bus.out_valid; i++) step();
  endtask

  initial begin
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.out_ready   = 1'b1;

    // 1: latency-1 memory, always ready
    do_reset();
    chk("boot_req", 32'(bus.imem_req), 32'h0);
    step();
    chk("c1_req", 32'(bus.imem_req), 32'h1);
    chk("c1_addr", bus.imem_addr, 32'h0);
    step();
    chk("c2_valid", 32'(bus.out_valid), 32'h0);
    step();
    chk("c3_valid", 32'(bus.out_valid), 32'h1);
    chk("c3_pc4", bus.out_pc4, 32'h4);
    repeat (12) step();

    // 2: decode stall fills the credit window
    bus.out_ready = 1'b0;
    do_reset();
    i0 = issues;
    repeat (20) step();
    chk("stall_issues", 32'(issues - i0), 32'h4);
    chk("stall_req", 32'(bus.imem_req), 32'h0);
    chk("stall_head", bus.out_pc4, 32'h4);
    bus.out_ready = 1'b1;
    i0 = delivered;
    repeat (15) step();
    chk("release_deliv", 32'(delivered - i0 >= 4), 32'h1);

    // 3: redirect with 2 queued and 2 outstanding
    bus.out_ready = 1'b0;
    do_reset();
    repeat (4) step();
    stall = 1;
    step();
    chk("t3_full_req", 32'(bus.imem_req), 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("t3_flush", 32'(bus.out_valid), 32'h0);
    stall = 0;
    bus.out_ready = 1'b1;
    wait_valid();
    chk("t3_first_valid", 32'(bus.out_valid), 32'h1);
    chk("t3_first_pc4", bus.out_pc4, 32'h104);
    repeat (10) step();

    // 4: redirect alongside rvalid, then back-to-back
    lat = 2;
    repeat (6) step();
    drive_mem();
    for (int i = 0; i < 10 && !bus.imem_rvalid; i++) begin
      step();
      drive_mem();
    end
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    wait_valid();
    chk("t4_first_pc4", bus.out_pc4, 32'h204);
    repeat (5) step();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    wait_valid();
    chk("t4_b2b_pc4", bus.out_pc4, 32'h404);
    repeat (8) step();

    // 5: address wrap
    lat = 1;
    bus.out_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    step();
    redirect = 1'b0;
    repeat (10) step();
    chk("wrap_0", bus.out_pc4, 32'h0);
    bus.out_ready = 1'b1;
    step();
    chk("wrap_4", bus.out_pc4, 32'h4);
    step();
    chk("wrap_8", bus.out_pc4, 32'h8);

    // 6: random traffic, then reset mid-burst
    for (int i = 0; i < 10000; i++) begin
      bus.imem_gnt  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      lat           = $urandom_range(1, 4);
      redirect      = ($urandom_range(0, 24) == 0);
      redirect_pc   = $urandom();
      step();
    end
    bus.imem_gnt  = 1'b1;
    bus.out_ready = 1'b1;
    redirect      = 1'b0;
    stall         = 0;
    lat           = 1;
    repeat (5) step();
    do_reset();
    step();
    chk("rr_req", 32'(bus.imem_req), 32'h1);
    chk("rr_addr", bus.imem_addr, 32'h0);
    i0 = delivered;
    repeat (10) step();
    chk("rr_deliv", 32'(delivered - i0 >= 4), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
